// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//
// Purpose:
//   Shared definitions for the instruction-memory loader.
//   - word_t:          the 32-bit instruction word type.
//   - loader_state_t:  the loader FSM states.
//   - length_in_range: decides whether a header length describes an image that
//                      fits in the instruction memory.
//
// Ports: none (package).
package program_loader_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  // Index of the last byte of a word inside the byte packer.
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  // A length is usable only when it is non-zero and no larger than the memory
  // depth. The compare is done at 33 bits so the whole 32-bit length counts:
  // a huge length whose low bits look small must still be rejected.
  function automatic logic length_in_range(input word_t len,
                                           input int unsigned addr_width);
    logic [32:0] depth;
    depth = 33'd1 << addr_width;
    return (len != '0) && ({1'b0, len} <= depth);
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer
//
// Purpose:
//   Packs a little-endian byte stream into 32-bit words. Each accepted byte is
//   shifted in at the top, so after four bytes b0..b3 the word is {b3,b2,b1,b0}.
//   The completed word is presented combinationally on word_next together with
//   word_complete, so the owner can capture it on the same edge that accepts
//   the 4th byte. The byte index wraps 3 -> 0 by itself, so the same packer is
//   reused for the length header and for every payload word.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   shift_en      in   a byte is accepted this cycle
//   byte_in       in   the byte being accepted
//   word_next     out  word including byte_in (valid when word_complete)
//   byte_idx      out  number of bytes already held for the current word (0..3)
//   word_complete out  shift_en on the 4th byte of a word
module byte_packer
  import program_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       shift_en,
  input  logic [7:0] byte_in,
  output word_t      word_next,
  output logic [1:0] byte_idx,
  output logic       word_complete
);

  word_t word_q;

  assign word_next     = {byte_in, word_q[31:8]};
  assign word_complete = shift_en && (byte_idx == LAST_BYTE_IDX);

  // Shift register and byte counter; the counter wraps so no explicit clear
  // is needed between the header and the payload words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (shift_en) begin
      word_q   <= word_next;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader
//
// Purpose:
//   Writer side of the instruction memory. Takes a framed program image from a
//   byte stream (valid/ready), writes it word by word into the instruction
//   memory and keeps the core in reset until the image has been loaded and its
//   XOR checksum has matched.
//
//   Frame: 4-byte little-endian word count L, L*4 payload bytes (words are
//   little-endian), then one checksum byte = XOR of all payload bytes.
//
// Parameters:
//   ADDR_WIDTH      word-address bits of the instruction memory
//   TIMEOUT_CYCLES  idle cycles allowed between bytes mid-frame, 0 = never
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   byte_valid    in   byte_data holds a valid byte
//   byte_data     in   stream byte
//   byte_ready    out  loader accepts a byte this cycle
//   imem_we       out  write strobe, one cycle per word
//   imem_addr     out  word address of the write
//   imem_wdata    out  word to write
//   core_hold     out  1 = keep the pipeline in reset
//   load_done     out  sticky: image loaded and checksum matched
//   load_error    out  sticky: frame rejected
//   words_loaded  out  number of words written so far
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output word_t                 imem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  // The idle counter fires when it is about to step from LIMIT-1 to LIMIT,
  // so the error shows exactly TIMEOUT_CYCLES cycles after the last byte.
  localparam logic  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam word_t IDLE_LAST  = word_t'(TIMEOUT_CYCLES) - 32'd1;

  loader_state_t       state;
  word_t               length_q;
  logic [7:0]          checksum_q;
  word_t               idle_cnt;

  logic                accept;
  logic                shift_en;
  logic                word_complete;
  logic [1:0]          byte_idx;
  word_t               packed_word;
  logic [ADDR_WIDTH:0] words_next;
  logic                last_word;
  logic                idle_counting;

  assign accept     = byte_valid && byte_ready;
  assign shift_en   = accept && ((state == HDR) || (state == LOAD));
  assign words_next = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // The word count is compared against the full 32-bit length.
  assign last_word  = (32'(words_next) == length_q);

  // In HDR the timeout only runs once a frame has actually started; with no
  // byte received the loader waits for the host indefinitely.
  assign idle_counting = TIMEOUT_EN &&
                         ((state == LOAD) || (state == CHECK) ||
                          ((state == HDR) && (byte_idx != 2'd0)));

  byte_packer u_packer (
    .clock         (clock),
    .reset         (reset),
    .shift_en      (shift_en),
    .byte_in       (byte_data),
    .word_next     (packed_word),
    .byte_idx      (byte_idx),
    .word_complete (word_complete)
  );

  // Loader FSM with all outputs registered. The write of a finished word is
  // issued on the edge that accepts its 4th byte, so imem_we is high for the
  // following cycle; the write therefore lands before any checksum byte can
  // be accepted, without ever throttling byte_ready. The timeout check sits
  // after the state case so it overrides it, but it only acts on cycles
  // without an accepted byte, when the case made no transition anyway.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= HDR;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      length_q     <= '0;
      checksum_q   <= '0;
      idle_cnt     <= '0;
    end else begin
      imem_we <= 1'b0;

      case (state)
        HDR: begin
          byte_ready <= 1'b1;
          if (word_complete) begin
            length_q   <= packed_word;
            checksum_q <= '0;
            if (length_in_range(packed_word, ADDR_WIDTH)) begin
              state <= LOAD;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
              byte_ready <= 1'b0;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            checksum_q <= checksum_q ^ byte_data;
            if (word_complete) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
              imem_wdata   <= packed_word;
              words_loaded <= words_next;
              if (last_word) begin
                state <= CHECK;
              end
            end
          end
        end

        CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == checksum_q) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end

        DONE: begin
          byte_ready <= 1'b0;
        end

        ERROR: begin
          byte_ready <= 1'b0;
        end

        default: begin
          state      <= ERROR;
          load_error <= 1'b1;
          byte_ready <= 1'b0;
        end
      endcase

      if (accept) begin
        idle_cnt <= '0;
      end else if (idle_counting) begin
        if (idle_cnt == IDLE_LAST) begin
          state      <= ERROR;
          load_error <= 1'b1;
          byte_ready <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//
// Purpose:
//   Self-checking bench for program_loader, built with a 16-word memory
//   (ADDR_WIDTH=4) and an 8-cycle idle timeout. A table of single-byte
//   vectors covers well-formed, bad-checksum and rejected-header frames;
//   hand-written sequences cover reset, the full-depth image, timeouts,
//   gapped streams and a reset in the middle of a load.
module tb_program_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 8;

  logic          clock;
  logic          reset;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int n_compared = 0;
  int n_failed   = 0;
  int we_count   = 0;
  int base_count;

  logic [31:0] mem_seen  [16];
  logic [31:0] frame_img [16];
  logic        acc_ok;

  typedef struct {
    logic        rst_before;
    logic [7:0]  data;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  words;
    logic        ready;
    logic        done;
    logic        error;
    logic        hold;
  } vec_t;

  vec_t vecs [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  program_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  // Memory model: records every write the loader issues.
  always @(posedge clock) begin
    if (imem_we) begin
      mem_seen[imem_addr] = imem_wdata;
      we_count++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Offers one byte (after an optional gap) and waits, bounded, for the
  // loader to take it. Returns just after the accepting edge with valid low.
  task automatic applyStimulus(input logic [7:0] b, input int gap, output logic ok);
    @(negedge clock);
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = byte_ready;
      @(posedge clock);
      if (!ok) @(negedge clock);
    end
    #1;
    byte_valid = 1'b0;
  endtask

  function automatic int pickGap(input int max_gap);
    if (max_gap <= 0) return 0;
    return int'($urandom_range(32'(max_gap), 0));
  endfunction

  // Sends a complete frame built from frame_img with a correct checksum.
  task automatic sendFrame(input int len, input int max_gap);
    logic [31:0] lw;
    logic [7:0]  b;
    logic [7:0]  cs;
    logic        ok;
    lw = 32'(len);
    cs = 8'h00;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(lw[8*k +: 8], pickGap(max_gap), ok);
      checkOutput("frame header accept", 32'(ok), 32'd1);
    end
    for (int w = 0; w < len; w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = frame_img[w][8*k +: 8];
        cs = cs ^ b;
        applyStimulus(b, pickGap(max_gap), ok);
        checkOutput("frame payload accept", 32'(ok), 32'd1);
      end
    end
    applyStimulus(cs, pickGap(max_gap), ok);
    checkOutput("frame checksum accept", 32'(ok), 32'd1);
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("reset imem_we", 32'(imem_we), 32'd0);
    checkOutput("reset imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset imem_wdata", imem_wdata, 32'd0);
    checkOutput("reset core_hold", 32'(core_hold), 32'd1);
    checkOutput("reset load_done", 32'(load_done), 32'd0);
    checkOutput("reset load_error", 32'(load_error), 32'd0);
    checkOutput("reset words_loaded", 32'(words_loaded), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("post-reset byte_ready", 32'(byte_ready), 32'd1);
    checkOutput("post-reset core_hold", 32'(core_hold), 32'd1);
  endtask

  function automatic void addVec(input logic rst, input logic [7:0] d, input logic we,
                                 input logic [3:0] a, input logic [31:0] wd,
                                 input logic [4:0] w, input logic r, input logic dn,
                                 input logic er, input logic h);
    vec_t v;
    v.rst_before = rst;
    v.data       = d;
    v.we         = we;
    v.addr       = a;
    v.wdata      = wd;
    v.words      = w;
    v.ready      = r;
    v.done       = dn;
    v.error      = er;
    v.hold       = h;
    vecs.push_back(v);
  endfunction

  // Global bound so the run always ends.
  initial begin
    #300000;
    n_failed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Frames A (checksum 7C, good) and B (checksum 7D, bad): 2 words 13, 6F.
    for (int f = 0; f < 2; f++) begin
      addVec(1'b1, 8'h02, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h13, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b1, 4'd0, 32'h00000013, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h6F, 1'b0, 4'd0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      addVec(1'b0, 8'h00, 1'b1, 4'd1, 32'h0000006F, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      if (f == 0)
        addVec(1'b0, 8'h7C, 1'b0, 4'd0, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      else
        addVec(1'b0, 8'h7D, 1'b0, 4'd0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    // Rejected headers: L=17 (too deep), L=0, L=0x01000010 (low bits look like 16).
    addVec(1'b1, 8'h11, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    addVec(1'b1, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    addVec(1'b1, 8'h10, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 8'h01, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset and idle header");
    resetDut();
    repeat (20) @(posedge clock);
    #1;
    checkOutput("hdr idle no timeout", 32'(load_error), 32'd0);
    checkOutput("hdr idle ready", 32'(byte_ready), 32'd1);

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) resetDut();
      applyStimulus(vecs[i].data, 0, acc_ok);
      checkOutput($sformatf("vec%0d accept", i), 32'(acc_ok), 32'd1);
      checkOutput($sformatf("vec%0d imem_we", i), 32'(imem_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        checkOutput($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
        checkOutput($sformatf("vec%0d imem_wdata", i), imem_wdata, vecs[i].wdata);
      end
      checkOutput($sformatf("vec%0d words_loaded", i), 32'(words_loaded), 32'(vecs[i].words));
      checkOutput($sformatf("vec%0d byte_ready", i), 32'(byte_ready), 32'(vecs[i].ready));
      checkOutput($sformatf("vec%0d load_done", i), 32'(load_done), 32'(vecs[i].done));
      checkOutput($sformatf("vec%0d load_error", i), 32'(load_error), 32'(vecs[i].error));
      checkOutput($sformatf("vec%0d core_hold", i), 32'(core_hold), 32'(vecs[i].hold));
    end
    checkOutput("table total writes", 32'(we_count), 32'd4);

    $display("[TB] full-depth image of 16 words");
    resetDut();
    for (int i = 0; i < 16; i++)
      frame_img[i] = 32'hC0DE0000 | (32'(i) << 8) | (32'(i) ^ 32'h55);
    base_count = we_count;
    sendFrame(16, 0);
    checkOutput("depth load_done", 32'(load_done), 32'd1);
    checkOutput("depth load_error", 32'(load_error), 32'd0);
    checkOutput("depth core_hold", 32'(core_hold), 32'd0);
    checkOutput("depth words_loaded", 32'(words_loaded), 32'd16);
    checkOutput("depth write count", 32'(we_count - base_count), 32'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("depth mem[%0d]", i), mem_seen[i], frame_img[i]);
    // Bytes offered after DONE must be ignored.
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    repeat (3) @(posedge clock);
    #1;
    byte_valid = 1'b0;
    checkOutput("after done writes", 32'(we_count - base_count), 32'd16);
    checkOutput("after done ready", 32'(byte_ready), 32'd0);
    checkOutput("after done load_done", 32'(load_done), 32'd1);
    checkOutput("after done words", 32'(words_loaded), 32'd16);

    $display("[TB] timeout in LOAD");
    resetDut();
    base_count = we_count;
    applyStimulus(8'h01, 0, acc_ok);
    applyStimulus(8'h00, 0, acc_ok);
    applyStimulus(8'h00, 0, acc_ok);
    applyStimulus(8'h00, 0, acc_ok);
    applyStimulus(8'hAA, 0, acc_ok);
    applyStimulus(8'hBB, 0, acc_ok);
    checkOutput("load timeout last accept", 32'(acc_ok), 32'd1);
    repeat (7) @(posedge clock);
    #1;
    checkOutput("load timeout early", 32'(load_error), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("load timeout error", 32'(load_error), 32'd1);
    checkOutput("load timeout ready", 32'(byte_ready), 32'd0);
    checkOutput("load timeout hold", 32'(core_hold), 32'd1);
    checkOutput("load timeout writes", 32'(we_count - base_count), 32'd0);

    $display("[TB] timeout in partial header");
    resetDut();
    applyStimulus(8'h05, 0, acc_ok);
    checkOutput("hdr timeout accept", 32'(acc_ok), 32'd1);
    repeat (7) @(posedge clock);
    #1;
    checkOutput("hdr timeout early", 32'(load_error), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("hdr timeout error", 32'(load_error), 32'd1);

    $display("[TB] gapped 3-word image");
    resetDut();
    frame_img[0] = 32'hDEADBEEF;
    frame_img[1] = 32'h00000013;
    frame_img[2] = 32'h12345678;
    base_count = we_count;
    sendFrame(3, 3);
    checkOutput("gapped load_done", 32'(load_done), 32'd1);
    checkOutput("gapped words", 32'(words_loaded), 32'd3);
    checkOutput("gapped writes", 32'(we_count - base_count), 32'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("gapped mem[%0d]", i), mem_seen[i], frame_img[i]);

    $display("[TB] reset in the middle of LOAD");
    resetDut();
    applyStimulus(8'h03, 0, acc_ok);
    applyStimulus(8'h00, 0, acc_ok);
    applyStimulus(8'h00, 0, acc_ok);
    applyStimulus(8'h00, 0, acc_ok);
    applyStimulus(8'h11, 0, acc_ok);
    applyStimulus(8'h22, 0, acc_ok);
    applyStimulus(8'h33, 0, acc_ok);
    applyStimulus(8'h44, 0, acc_ok);
    checkOutput("midload imem_we", 32'(imem_we), 32'd1);
    checkOutput("midload imem_wdata", imem_wdata, 32'h44332211);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset imem_we", 32'(imem_we), 32'd0);
    checkOutput("async reset imem_wdata", imem_wdata, 32'd0);
    checkOutput("async reset byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("async reset words", 32'(words_loaded), 32'd0);
    checkOutput("async reset core_hold", 32'(core_hold), 32'd1);
    resetDut();
    frame_img[0] = 32'hCAFEF00D;
    frame_img[1] = 32'h0BADC0DE;
    base_count = we_count;
    sendFrame(2, 2);
    checkOutput("reload load_done", 32'(load_done), 32'd1);
    checkOutput("reload load_error", 32'(load_error), 32'd0);
    checkOutput("reload words", 32'(words_loaded), 32'd2);
    checkOutput("reload writes", 32'(we_count - base_count), 32'd2);
    checkOutput("reload mem[0]", mem_seen[0], 32'hCAFEF00D);
    checkOutput("reload mem[1]", mem_seen[1], 32'h0BADC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
